// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: halts the CPU and copies a page of memory into OAM when the CPU writes the DMA trigger register
module oam_dma_arbiter #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256,
  parameter int          READ_LATENCY  = 2,
  parameter int          SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_write_en,
  output logic        bus_read_en,
  input  logic [7:0]  bus_data_in,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic        dma_done
);
  typedef enum logic [2:0] {IDLE, SETTLE, RD, RD_WAIT, CAP, WR, DONE} state_t;
  localparam logic [8:0] LAST        = 9'(XFER_LEN - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(READ_LATENCY - 2);
  state_t      state;
  logic [7:0]  page, latch, tmr;
  logic [8:0]  cnt;
  logic        prev_we, own, trig, src_phase;
  assign own       = state != IDLE;
  assign src_phase = state == RD || state == RD_WAIT || state == CAP;
  assign trig      = state == IDLE && cpu_write_en && !prev_we && cpu_addr == TRIGGER_ADDR;
  // CPU strobes are masked while DMA owns the bus, since a halted CPU may sit with write_en held high
  always_comb begin
    bus_addr     = !own ? cpu_addr : state == WR ? OAM_DATA_ADDR : src_phase ? {page, cnt[7:0]} : 16'h0000;
    bus_data_out = !own ? cpu_data_out : state == WR ? latch : 8'h00;
    bus_write_en = own ? state == WR : cpu_write_en;
    bus_read_en  = own ? state == RD : cpu_read_en;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cpu_halt   <= 1'b0;
      dma_active <= 1'b0;
      dma_done   <= 1'b0;
      page       <= 8'h00;
      cnt        <= 9'd0;
      latch      <= 8'h00;
      tmr        <= 8'h00;
      prev_we    <= 1'b0;
    end else begin
      prev_we  <= cpu_write_en;
      dma_done <= 1'b0;
      case (state)
        IDLE: if (trig) begin
          page       <= cpu_data_out;
          cnt        <= 9'd0;
          tmr        <= 8'h00;
          cpu_halt   <= 1'b1;
          dma_active <= 1'b1;
          state      <= SETTLE;
        end
        SETTLE: if (tmr == SETTLE_LAST) state <= RD; else tmr <= tmr + 8'd1;
        RD: begin
          tmr   <= 8'h00;
          state <= (READ_LATENCY == 1) ? CAP : RD_WAIT;
        end
        RD_WAIT: if (tmr == WAIT_LAST) state <= CAP; else tmr <= tmr + 8'd1;
        CAP: begin
          latch <= bus_data_in;
          state <= WR;
        end
        WR: if (cnt == LAST) begin
          dma_done <= 1'b1;
          state    <= DONE;
        end else begin
          cnt   <= cnt + 9'd1;
          state <= RD;
        end
        default: begin
          cpu_halt   <= 1'b0;
          dma_active <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: directed scenarios against a default instance and a short, slow-memory instance
module tb_oam_dma_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, n_cmp = 0, n_err = 0;
  logic [15:0] a_addr = 16'h0000, b_addr = 16'h0000;
  logic [7:0]  a_dout = 8'h00, b_dout = 8'h00;
  logic        a_we = 1'b0, a_re = 1'b0, b_we = 1'b0, b_re = 1'b0;
  logic [15:0] a_baddr, b_baddr;
  logic [7:0]  a_bdo, a_bdi, b_bdo, b_bdi;
  logic        a_bwe, a_bre, a_halt, a_act, a_done;
  logic        b_bwe, b_bre, b_halt, b_act, b_done;
  logic [16:0] pa [2];
  logic [16:0] pb [3];
  int a_halt_n = 0, a_done_n = 0, b_halt_n = 0, b_done_n = 0;
  logic [15:0] a_wa [$];
  logic [7:0]  a_wd [$];
  int          a_wt [$];
  logic [15:0] a_ra [$];
  logic [7:0]  b_wd [$];
  int          b_wt [$];
  int          b_rt [$];
  logic [15:0] b_ra [$];

  oam_dma_arbiter dut_a (
    .clk(clk), .rst(rst), .cpu_addr(a_addr), .cpu_data_out(a_dout), .cpu_write_en(a_we),
    .cpu_read_en(a_re), .bus_addr(a_baddr), .bus_data_out(a_bdo), .bus_write_en(a_bwe),
    .bus_read_en(a_bre), .bus_data_in(a_bdi), .cpu_halt(a_halt), .dma_active(a_act), .dma_done(a_done)
  );
  oam_dma_arbiter #(.READ_LATENCY(3), .XFER_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .cpu_addr(b_addr), .cpu_data_out(b_dout), .cpu_write_en(b_we),
    .cpu_read_en(b_re), .bus_addr(b_baddr), .bus_data_out(b_bdo), .bus_write_en(b_bwe),
    .bus_read_en(b_bre), .bus_data_in(b_bdi), .cpu_halt(b_halt), .dma_active(b_act), .dma_done(b_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory holds addr[7:0]^5A everywhere; data appears READ_LATENCY cycles after the strobe, 00 otherwise
  always @(posedge clk) begin
    pa[0] <= {a_bre, a_baddr};
    pa[1] <= pa[0];
    pb[0] <= {b_bre, b_baddr};
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign a_bdi = pa[1][16] ? (pa[1][7:0] ^ 8'h5A) : 8'h00;
  assign b_bdi = pb[2][16] ? (pb[2][7:0] ^ 8'h5A) : 8'h00;

  always @(negedge clk) begin
    if (a_halt) a_halt_n++;
    if (a_done) a_done_n++;
    if (a_act && a_bwe) begin a_wa.push_back(a_baddr); a_wd.push_back(a_bdo); a_wt.push_back(cyc); end
    if (a_act && a_bre) a_ra.push_back(a_baddr);
    if (b_halt) b_halt_n++;
    if (b_done) b_done_n++;
    if (b_act && b_bwe) begin b_wd.push_back(b_bdo); b_wt.push_back(cyc); end
    if (b_act && b_bre) begin b_ra.push_back(b_baddr); b_rt.push_back(cyc); end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit on_b, input int budget);
    int t = 0;
    while ((on_b ? b_done : a_done) !== 1'b1 && t < budget) begin @(negedge clk); t++; end
    n_cmp++;
    if ((on_b ? b_done : a_done) !== 1'b1) begin
      n_err++; $display("FAIL done_timeout: got no dma_done after %0d cycles, want a pulse within %0d", t, budget);
    end
  endtask

  task automatic test_reset();
    a_addr = 16'h1234; a_dout = 8'hAB; a_we = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({a_halt, a_act, a_done, b_halt, b_act, b_done} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 000000", {a_halt, a_act, a_done, b_halt, b_act, b_done});
    end
    n_cmp++;
    if ({a_bwe, a_bre, a_baddr, a_bdo} !== {1'b1, 1'b0, 16'h1234, 8'hAB}) begin
      n_err++; $display("FAIL reset_passthru: got we=%b re=%b addr=%h data=%h want 1 0 1234 ab", a_bwe, a_bre, a_baddr, a_bdo);
    end
    tick(); rst = 1'b1; a_we = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_page02();
    int h0 = a_halt_n, d0 = a_done_n, w0 = a_wa.size(), r0 = a_ra.size(), bad = 0, bad_t = 0;
    tick(); a_addr = 16'h4014; a_dout = 8'h02; a_we = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_bwe, a_baddr, a_bdo, a_halt} !== {1'b1, 16'h4014, 8'h02, 1'b0}) begin
      n_err++; $display("FAIL trig_write_passes: got we=%b addr=%h data=%h halt=%b want 1 4014 02 0", a_bwe, a_baddr, a_bdo, a_halt);
    end
    tick(); a_we = 1'b0;
    wait_done(1'b0, 1200);
    repeat (3) tick();
    n_cmp++;
    if (a_halt_n - h0 !== 1027) begin n_err++; $display("FAIL p02_halt_len: got %0d want 1027", a_halt_n - h0); end
    n_cmp++;
    if (a_done_n - d0 !== 1) begin n_err++; $display("FAIL p02_done_pulses: got %0d want 1", a_done_n - d0); end
    n_cmp++;
    if (a_wa.size() - w0 !== 256) begin n_err++; $display("FAIL p02_write_count: got %0d want 256", a_wa.size() - w0); end
    for (int i = 0; i < 256 && w0 + i < a_wa.size(); i++) begin
      if (a_wa[w0 + i] !== 16'h2004 || a_wd[w0 + i] !== (8'(i) ^ 8'h5A)) bad++;
      if (i > 0 && a_wt[w0 + i] - a_wt[w0 + i - 1] != 4) bad_t++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL p02_write_data: got %0d wrong writes want 0", bad); end
    n_cmp++;
    if (bad_t !== 0) begin n_err++; $display("FAIL p02_write_spacing: got %0d gaps not 4 cycles want 0", bad_t); end
    n_cmp++;
    if ({a_ra[r0], a_ra[r0 + 255]} !== {16'h0200, 16'h02FF}) begin
      n_err++; $display("FAIL p02_read_range: got %h..%h want 0200..02ff", a_ra[r0], a_ra[r0 + 255]);
    end
  endtask

  task automatic test_page_ff();
    int r0 = a_ra.size(), bad = 0;
    tick(); a_addr = 16'h4014; a_dout = 8'hFF; a_we = 1'b1;
    tick(); a_we = 1'b0;
    wait_done(1'b0, 1200);
    repeat (3) tick();
    n_cmp++;
    if (a_ra.size() - r0 !== 256) begin n_err++; $display("FAIL pff_read_count: got %0d want 256", a_ra.size() - r0); end
    for (int i = r0; i < a_ra.size(); i++) if (a_ra[i][15:8] !== 8'hFF) bad++;
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL pff_no_wrap: got %0d reads outside ff00..ffff want 0", bad); end
    n_cmp++;
    if ({a_ra[r0], a_ra[a_ra.size() - 1]} !== {16'hFF00, 16'hFFFF}) begin
      n_err++; $display("FAIL pff_read_ends: got %h..%h want ff00..ffff", a_ra[r0], a_ra[a_ra.size() - 1]);
    end
  endtask

  task automatic test_held_write();
    int w0 = a_wa.size(), d0 = a_done_n, bad = 0;
    tick(); a_addr = 16'h4014; a_dout = 8'h01; a_we = 1'b1;
    tick();
    wait_done(1'b0, 1200);
    repeat (10) tick();
    @(negedge clk);
    n_cmp++;
    if ({a_halt, a_act} !== 2'b00) begin n_err++; $display("FAIL held_no_retrigger: got halt=%b act=%b want 0 0", a_halt, a_act); end
    n_cmp++;
    if (a_wa.size() - w0 !== 256 || a_done_n - d0 !== 1) begin
      n_err++; $display("FAIL held_write_count: got %0d writes %0d dones want 256 1", a_wa.size() - w0, a_done_n - d0);
    end
    for (int i = w0; i < a_wa.size(); i++) if (a_wa[i] !== 16'h2004) bad++;
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL held_write_addr: got %0d writes off 2004 want 0", bad); end
    tick(); a_we = 1'b0;
    tick(); a_we = 1'b1;
    tick(); a_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_halt !== 1'b1) begin n_err++; $display("FAIL held_new_edge: got halt=%b want 1", a_halt); end
    wait_done(1'b0, 1200);
    repeat (2) tick();
  endtask

  task automatic test_pass_through();
    int h0 = a_halt_n;
    tick(); a_addr = 16'h4015; a_dout = 8'h77; a_we = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_bwe, a_bre, a_baddr, a_bdo} !== {1'b1, 1'b0, 16'h4015, 8'h77}) begin
      n_err++; $display("FAIL pt_write: got we=%b re=%b addr=%h data=%h want 1 0 4015 77", a_bwe, a_bre, a_baddr, a_bdo);
    end
    tick(); a_we = 1'b0; a_addr = 16'h4014; a_re = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_bwe, a_bre, a_baddr} !== {1'b0, 1'b1, 16'h4014}) begin
      n_err++; $display("FAIL pt_read: got we=%b re=%b addr=%h want 0 1 4014", a_bwe, a_bre, a_baddr);
    end
    tick(); a_re = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (a_halt_n - h0 !== 0 || a_act !== 1'b0) begin
      n_err++; $display("FAIL pt_no_halt: got %0d halt cycles act=%b want 0 0", a_halt_n - h0, a_act);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = a_wa.size(), r1, t = 0;
    tick(); a_addr = 16'h4014; a_dout = 8'h02; a_we = 1'b1;
    tick(); a_we = 1'b0; a_addr = 16'h1111;
    while (a_wa.size() - w0 < 100 && t < 1000) begin @(negedge clk); t++; end
    n_cmp++;
    if (a_wa.size() - w0 !== 100) begin n_err++; $display("FAIL rm_reach_byte100: got %0d writes want 100", a_wa.size() - w0); end
    tick(); rst = 1'b0;
    #1;
    n_cmp++;
    if ({a_halt, a_act, a_done, a_bre, a_bwe, a_baddr} !== {5'b0, 16'h1111}) begin
      n_err++; $display("FAIL rm_async: got halt=%b act=%b done=%b re=%b we=%b addr=%h want 0 0 0 0 0 1111",
                        a_halt, a_act, a_done, a_bre, a_bwe, a_baddr);
    end
    repeat (2) tick();
    rst = 1'b1;
    r1 = a_ra.size();
    repeat (10) tick();
    n_cmp++;
    if (a_ra.size() !== r1 || a_halt !== 1'b0) begin
      n_err++; $display("FAIL rm_no_resume: got %0d reads halt=%b want 0 0", a_ra.size() - r1, a_halt);
    end
    a_addr = 16'h4014; a_dout = 8'h03; a_we = 1'b1;
    tick(); a_we = 1'b0;
    wait_done(1'b0, 1200);
    repeat (2) tick();
    n_cmp++;
    if ({a_ra[r1], a_ra.size() - r1} !== {16'h0300, 32'd256}) begin
      n_err++; $display("FAIL rm_restart: got first=%h count=%0d want 0300 256", a_ra[r1], a_ra.size() - r1);
    end
  endtask

  task automatic test_short();
    logic [7:0] exp_d [4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};
    int h0 = b_halt_n, d0 = b_done_n, w0 = b_wd.size(), r0 = b_ra.size(), bad = 0;
    tick(); b_addr = 16'h4014; b_dout = 8'h05; b_we = 1'b1;
    tick(); b_we = 1'b0;
    wait_done(1'b1, 100);
    repeat (3) tick();
    n_cmp++;
    if (b_halt_n - h0 !== 23) begin n_err++; $display("FAIL short_halt_len: got %0d want 23", b_halt_n - h0); end
    n_cmp++;
    if (b_wd.size() - w0 !== 4 || b_done_n - d0 !== 1) begin
      n_err++; $display("FAIL short_counts: got %0d writes %0d dones want 4 1", b_wd.size() - w0, b_done_n - d0);
    end
    for (int i = 0; i < 4 && w0 + i < b_wd.size(); i++) begin
      if (b_wd[w0 + i] !== exp_d[i] || b_ra[r0 + i] !== (16'h0500 + 16'(i))) bad++;
      if (i > 0 && b_wt[w0 + i] - b_wt[w0 + i - 1] != 5) bad++;
      if (b_wt[w0 + i] - b_rt[r0 + i] != 4) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL short_bytes: got %0d data/address/timing errors want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_page02();
    test_page_ff();
    test_held_write();
    test_pass_through();
    test_reset_mid();
    test_short();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
